// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
// Turns one command (read or write) into a single AXI4-Lite transaction and
// returns the slave's response through a valid/ready response port.
// Only one transaction is in flight at a time.
// Optional feature: define AXI_LITE_MASTER_TIMEOUT_EN to add a handshake
// watchdog that aborts a stalled transaction with SLVERR and rsp_timeout=1.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    reset_n,
   // command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // response port
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic                    busy,
   // AXI4-Lite write address / data / response
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   // AXI4-Lite read address / data
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam int STRB_WIDTH = DATA_WIDTH/8;

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $error("axi_lite_cmd_master: DATA_WIDTH must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("axi_lite_cmd_master: TIMEOUT_CYCLES must be within 2..65535");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;
   logic                  w_timeout;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   logic [15:0] r_wdog;
   logic        r_rsp_timeout;
   logic        w_wait_state;

   assign w_wait_state = (r_state == WR) || (r_state == WR_RESP) ||
                         (r_state == RD_ADDR) || (r_state == RD_DATA);
   assign w_timeout    = w_wait_state && (r_wdog == 16'(TIMEOUT_CYCLES - 1));
   assign rsp_timeout  = r_rsp_timeout;

   // Watchdog: restarts on every state change, counts cycles spent waiting on a handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_wdog <= '0;
      else if (w_state_nxt != r_state)
         r_wdog <= '0;
      else if (w_wait_state)
         r_wdog <= r_wdog + 16'd1;
   end

   // Timeout flag is decided on the transition into RSP and held through it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_rsp_timeout <= 1'b0;
      else if ((w_state_nxt == RSP) && (r_state != RSP))
         r_rsp_timeout <= w_timeout;
   end
`else
   assign w_timeout   = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and handshake outputs; an abort drops every AXI valid/ready at once
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      rsp_valid   = 1'b0;
      awvalid     = 1'b0;
      wvalid      = 1'b0;
      bready      = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid)
               w_state_nxt = cmd_write ? WR : RD_ADDR;
         end
         WR: begin
            awvalid = !r_aw_done && !w_timeout;
            wvalid  = !r_w_done && !w_timeout;
            if (w_timeout)
               w_state_nxt = RSP;
            else if ((r_aw_done || awready) && (r_w_done || wready))
               w_state_nxt = WR_RESP;
         end
         WR_RESP: begin
            bready = !w_timeout;
            if (w_timeout || bvalid)
               w_state_nxt = RSP;
         end
         RD_ADDR: begin
            arvalid = !w_timeout;
            if (w_timeout)
               w_state_nxt = RSP;
            else if (arready)
               w_state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rready = !w_timeout;
            if (w_timeout || rvalid)
               w_state_nxt = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Per-channel completion flags let AW and W finish in any order
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (r_state == IDLE) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (r_state == WR) begin
         if (awvalid && awready)
            r_aw_done <= 1'b1;
         if (wvalid && wready)
            r_w_done <= 1'b1;
      end
   end

   // Command fields are captured on acceptance so AXI outputs stay stable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if ((r_state == IDLE) && cmd_valid) begin
         r_addr  <= cmd_addr;
         r_wdata <= cmd_wdata;
         r_wstrb <= cmd_wstrb;
      end
   end

   // Response capture: B for writes (read data forced to 0), R for reads, SLVERR on abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else if (w_timeout) begin
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b10;
      end else if ((r_state == WR_RESP) && bvalid) begin
         r_rsp_rdata <= '0;
         r_rsp_resp  <= bresp;
      end else if ((r_state == RD_DATA) && rvalid) begin
         r_rsp_rdata <= rdata;
         r_rsp_resp  <= rresp;
      end
   end

   assign awaddr    = r_addr;
   assign araddr    = r_addr;
   assign wdata     = r_wdata;
   assign wstrb     = r_wstrb;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Testbench for axi_lite_cmd_master: directed commands against a configurable
// AXI4-Lite slave, with a timeline model of when each handshake and the
// response must appear.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW/8;
   localparam int TO = 16;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp = 2'b00, rresp = 2'b00;
   logic          bvalid = 1'b0, bready, arvalid, arready = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          rvalid = 1'b0, rready;

   axi_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // slave behaviour knobs (cycles of stall before ready/valid)
   int          s_aw_wait = 0, s_w_wait = 0, s_b_wait = 0, s_ar_wait = 0, s_r_wait = 0;
   logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
   logic [31:0] s_rdata = '0;
   int          r_hold = 0;
   // slave state
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, nb_hs;
   logic        aw_got, w_got, ar_got;
   // model: expected timeline of the current transaction, in edge counts
   int          edges;
   logic        m_active, m_write, m_to;
   int          m_k, m_aw_end, m_w_end, m_b_lo, m_b_hi, m_ar_end, m_r_lo, m_r_hi, m_rsp_lo;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_resp;

   // slave bookkeeping and model advance at each rising edge
   always @(posedge clk or negedge reset_n) begin
      int   e_old, mx, lim;
      logic was_active;
      if (!reset_n) begin
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         aw_got = 0; w_got = 0; ar_got = 0; m_active = 0;
      end else begin
         e_old = edges;
         edges = edges + 1;
         if (bvalid && bready) begin nb_hs++; aw_got = 0; w_got = 0; b_cnt = 0; end
         else if (aw_got && w_got) b_cnt++;
         if (rvalid && rready) begin ar_got = 0; r_cnt = 0; end
         else if (ar_got) r_cnt++;
         if (awvalid && awready) begin aw_got = 1; aw_cnt = 0; end
         else if (awvalid) aw_cnt++; else aw_cnt = 0;
         if (wvalid && wready) begin w_got = 1; w_cnt = 0; end
         else if (wvalid) w_cnt++; else w_cnt = 0;
         if (arvalid && arready) begin ar_got = 1; ar_cnt = 0; end
         else if (arvalid) ar_cnt++; else ar_cnt = 0;

         was_active = m_active;
         if (m_active && e_old >= m_rsp_lo && rsp_ready) m_active = 0;
         if (!was_active && cmd_valid) begin
            aw_got = 0; w_got = 0; ar_got = 0; b_cnt = 0; r_cnt = 0;
            m_active = 1; m_write = cmd_write; m_k = edges;
            m_addr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
            lim = TO_EN ? TO - 2 : 32'h3fff_ffff;
            m_to = 0; m_rdata = '0;
            m_aw_end = -1; m_w_end = -1; m_b_lo = 1; m_b_hi = 0;
            m_ar_end = -1; m_r_lo = 1; m_r_hi = 0;
            if (cmd_write) begin
               mx = (s_aw_wait > s_w_wait) ? s_aw_wait : s_w_wait;
               if (mx > lim) begin
                  m_aw_end = m_k + ((s_aw_wait > lim) ? lim : s_aw_wait);
                  m_w_end  = m_k + ((s_w_wait > lim) ? lim : s_w_wait);
                  m_rsp_lo = m_k + TO; m_resp = 2'b10; m_to = 1;
               end else begin
                  m_aw_end = m_k + s_aw_wait; m_w_end = m_k + s_w_wait;
                  m_b_lo = m_k + 1 + mx; m_b_hi = m_b_lo + s_b_wait;
                  m_rsp_lo = m_b_hi + 1; m_resp = s_bresp;
               end
            end else begin
               m_ar_end = m_k + s_ar_wait;
               m_r_lo = m_ar_end + 1; m_r_hi = m_r_lo + s_r_wait;
               m_rsp_lo = m_r_hi + 1; m_resp = s_rresp; m_rdata = s_rdata;
            end
         end
      end
   end

   // compare every cycle at the falling edge, then drive the slave and rsp_ready
   always @(negedge clk) begin
      int e;
      e = edges;
      if (reset_n) begin
         chk("cmd_ready", cmd_ready, !m_active);
         chk("busy", busy, m_active);
         chk("awvalid", awvalid, m_active && m_write && e >= m_k && e <= m_aw_end);
         chk("wvalid", wvalid, m_active && m_write && e >= m_k && e <= m_w_end);
         chk("bready", bready, m_active && e >= m_b_lo && e <= m_b_hi);
         chk("arvalid", arvalid, m_active && !m_write && e >= m_k && e <= m_ar_end);
         chk("rready", rready, m_active && e >= m_r_lo && e <= m_r_hi);
         chk("rsp_valid", rsp_valid, m_active && e >= m_rsp_lo);
         if (m_active && e >= m_rsp_lo) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_resp", rsp_resp, m_resp);
            chk("rsp_timeout", rsp_timeout, m_to);
         end
         if (awvalid) chk("awaddr", awaddr, m_addr);
         if (wvalid) begin chk("wdata", wdata, m_wdata); chk("wstrb", wstrb, m_wstrb); end
         if (arvalid) chk("araddr", araddr, m_addr);
      end
      awready = awvalid && (aw_cnt >= s_aw_wait);
      wready  = wvalid && (w_cnt >= s_w_wait);
      bvalid  = aw_got && w_got && (b_cnt >= s_b_wait);
      bresp   = bvalid ? s_bresp : 2'b00;
      arready = arvalid && (ar_cnt >= s_ar_wait);
      rvalid  = ar_got && (r_cnt >= s_r_wait);
      rdata   = rvalid ? s_rdata : '0;
      rresp   = rvalid ? s_rresp : 2'b00;
      rsp_ready = m_active && (e >= m_rsp_lo + r_hold);
   end

   logic av_h [1:20];
   logic wv_h [1:20];

   // issue one command (caller is at a falling edge) and run it to completion
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                         input logic [3:0] strb, output int lat, output logic [31:0] rd,
                         output logic [1:0] rs, output logic to);
      lat = 0; rd = '0; rs = 2'b00; to = 1'b0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = dat; cmd_wstrb = strb;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin av_h[i] = 1'b0; wv_h[i] = 1'b0; end
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i <= 20) begin av_h[i] = awvalid; wv_h[i] = wvalid; end
         if (rsp_valid && lat == 0) begin lat = i; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout; end
         if (!m_active) break;
      end
      chk("rsp_seen", (lat != 0), 1'b1);
   endtask

   initial begin
      int          lat, nb0;
      logic [31:0] rd;
      logic [1:0]  rs;
      logic        to;
      edges = 0; nb_hs = 0;
      #3;
      // reset values while reset_n is low
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
      chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'd0);
      chk("rst_addr", {awaddr, araddr, wdata, wstrb}, 100'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // write with an always-ready slave: response on the third cycle
      nb0 = nb_hs;
      do_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, lat, rd, rs, to);
      chk("wr_lat", lat, 3);
      chk("wr_rdata", rd, 32'h0);
      chk("wr_resp", rs, 2'b00);
      chk("wr_bhs", nb_hs - nb0, 1);

      // awready late by 4 cycles, wready immediate
      s_aw_wait = 4; nb0 = nb_hs;
      do_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, lat, rd, rs, to);
      chk("aw4_wv_c1", wv_h[1], 1'b1);
      chk("aw4_wv_c2", wv_h[2], 1'b0);
      chk("aw4_av_c5", av_h[5], 1'b1);
      chk("aw4_av_c6", av_h[6], 1'b0);
      chk("aw4_lat", lat, 7);
      chk("aw4_bhs", nb_hs - nb0, 1);
      s_aw_wait = 0;

      // plain read, back-to-back with the previous write
      s_rdata = 32'hCAFE_F00D;
      do_cmd(1'b0, 32'h0000_1004, 32'h0, 4'h0, lat, rd, rs, to);
      chk("rd_lat", lat, 3);
      chk("rd_rdata", rd, 32'hCAFE_F00D);
      chk("rd_resp", rs, 2'b00);

      // read with SLVERR, response consumer stalls 5 cycles
      s_rdata = 32'h0BAD_0BAD; s_rresp = 2'b10; r_hold = 5;
      do_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h0, lat, rd, rs, to);
      chk("rdhold_rdata", rd, 32'h0BAD_0BAD);
      chk("rdhold_resp", rs, 2'b10);
      s_rresp = 2'b00; r_hold = 0;

      // W late, AW late, B late, partial strobe, OKAY-exclusive response
      s_aw_wait = 1; s_w_wait = 3; s_b_wait = 2; s_bresp = 2'b01;
      do_cmd(1'b1, 32'h0000_0300, 32'hA5A5_0F0F, 4'h3, lat, rd, rs, to);
      chk("wlate_lat", lat, 8);
      chk("wlate_resp", rs, 2'b01);
      s_aw_wait = 0; s_w_wait = 0; s_b_wait = 0; s_bresp = 2'b00;

      // AR and R both delayed
      s_ar_wait = 2; s_r_wait = 3; s_rdata = 32'h7654_3210;
      do_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, lat, rd, rs, to);
      chk("rlate_lat", lat, 8);
      chk("rlate_rdata", rd, 32'h7654_3210);
      s_ar_wait = 0; s_r_wait = 0;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      // awready never arrives: watchdog aborts after TO cycles in WR
      s_aw_wait = 100000;
      do_cmd(1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF, lat, rd, rs, to);
      chk("to_lat", lat, TO + 1);
      chk("to_flag", to, 1'b1);
      chk("to_resp", rs, 2'b10);
      chk("to_av_c15", av_h[15], 1'b1);
      chk("to_av_c16", av_h[16], 1'b0);
      s_aw_wait = 0;
      do_cmd(1'b1, 32'h0000_0044, 32'h3333_4444, 4'hF, lat, rd, rs, to);
      chk("to_next_lat", lat, 3);
      chk("to_next_flag", to, 1'b0);
`endif

      // reset asserted while waiting for read data
      s_r_wait = 30; s_rdata = 32'h5555_AAAA;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rready) break;
      end
      chk("rst_mid_rready", rready, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_cmd_ready", cmd_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      chk("arst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
      chk("arst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'd0);
      chk("arst_addr", {awaddr, araddr, wdata, wstrb}, 100'd0);
      @(negedge clk);
      reset_n = 1'b1;
      s_r_wait = 0;
      repeat (6) @(negedge clk);
      s_rdata = 32'h0F1E_2D3C;
      do_cmd(1'b0, 32'h0000_0084, 32'h0, 4'h0, lat, rd, rs, to);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_rdata", rd, 32'h0F1E_2D3C);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
